// File: rtl/march_pkg.sv
// Shared types and per-element tables for the March C- sequencer.
// Bit e of each table describes march element e.
package march_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

   localparam int NUM_ELEM = 6;
   localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

   localparam logic [NUM_ELEM-1:0] ELEM_TWO_OPS = 6'b011110;
   localparam logic [NUM_ELEM-1:0] ELEM_DOWN    = 6'b011000;
   localparam logic [NUM_ELEM-1:0] OP0_WRITE    = 6'b000001;
   localparam logic [NUM_ELEM-1:0] OP0_BIT      = 6'b010100;
   localparam logic [NUM_ELEM-1:0] OP1_BIT      = 6'b001010;

   typedef struct packed {
      logic we;
      logic wbit;
      logic expbit;
   } mem_op_t;

   function automatic logic elem_two_ops(input logic [2:0] e);
      return (int'(e) < NUM_ELEM) ? ELEM_TWO_OPS[e] : 1'b0;
   endfunction

   function automatic logic elem_down(input logic [2:0] e);
      return (int'(e) < NUM_ELEM) ? ELEM_DOWN[e] : 1'b0;
   endfunction

   // Pattern bit lands on wbit for writes and on expbit for reads; the other stays 0.
   function automatic mem_op_t op_decode(input logic [2:0] e, input logic op);
      mem_op_t r;
      logic    b;
      r = '0;
      if (int'(e) < NUM_ELEM) begin
         if (op) begin
            r.we   = 1'b1;
            r.wbit = OP1_BIT[e];
         end else begin
            b        = OP0_BIT[e];
            r.we     = OP0_WRITE[e];
            r.wbit   = OP0_WRITE[e] & b;
            r.expbit = ~OP0_WRITE[e] & b;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/addr_updown_cnt.sv
// Loadable up/down address counter; end detection is an equality compare,
// so a full-range sweep never relies on carry-out.
module addr_updown_cnt #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              en,
   input  logic              up,
   input  logic [ADDR_W-1:0] end_val,
   output logic [ADDR_W-1:0] cnt,
   output logic              at_end
);

   assign at_end = (cnt == end_val);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
      end
   end

endmodule

// File: rtl/march_seq_ctrl.sv
// March C- BIST sequencer: walks elements E0..E5 over 0..last_addr and
// presents one memory op at a time on a req/ready handshake.
module march_seq_ctrl
   import march_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_last_addr,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_wbit,
   output logic              mem_expbit,
   output logic [2:0]        elem_idx,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   state_t            state;
   logic              op;
   logic [ADDR_W-1:0] last_addr;
   logic [2:0]        elem_nxt;
   logic              accept;
   logic              last_op;
   logic              at_end;
   logic              cnt_load;
   logic              cnt_en;
   logic              cnt_up;
   logic [ADDR_W-1:0] cnt_load_val;
   logic [ADDR_W-1:0] cnt_end;

   always_comb begin
      elem_nxt     = elem_idx + 3'd1;
      accept       = (state == ST_RUN) && mem_ready && !abort;
      last_op      = op || !elem_two_ops(elem_idx);
      cnt_up       = !elem_down(elem_idx);
      cnt_end      = elem_down(elem_idx) ? '0 : last_addr;
      cnt_en       = accept && last_op && !at_end;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      if ((state == ST_IDLE) && start) begin
         cnt_load = 1'b1;
      end else if (accept && last_op && at_end && (elem_idx != LAST_ELEM)) begin
         // next element starts at its own end of the range
         cnt_load     = 1'b1;
         cnt_load_val = elem_down(elem_nxt) ? last_addr : '0;
      end
   end

   addr_updown_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (cnt_en),
      .up       (cnt_up),
      .end_val  (cnt_end),
      .cnt      (mem_addr),
      .at_end   (at_end)
   );

   always_ff @(posedge clk) begin
      if ((state == ST_IDLE) && start) begin
         last_addr <= cfg_last_addr;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= ST_IDLE;
         elem_idx   <= '0;
         op         <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_wbit   <= 1'b0;
         mem_expbit <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_RUN;
                  elem_idx <= '0;
                  op       <= 1'b0;
                  mem_req  <= 1'b1;
                  busy     <= 1'b1;
                  aborted  <= 1'b0;
                  {mem_we, mem_wbit, mem_expbit} <= op_decode(3'd0, 1'b0);
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state   <= ST_FIN;
                  mem_req <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  aborted <= 1'b1;
                  {mem_we, mem_wbit, mem_expbit} <= '0;
               end else if (mem_ready) begin
                  if (!last_op) begin
                     op <= 1'b1;
                     {mem_we, mem_wbit, mem_expbit} <= op_decode(elem_idx, 1'b1);
                  end else if (!at_end) begin
                     op <= 1'b0;
                     {mem_we, mem_wbit, mem_expbit} <= op_decode(elem_idx, 1'b0);
                  end else if (elem_idx == LAST_ELEM) begin
                     state   <= ST_FIN;
                     mem_req <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     {mem_we, mem_wbit, mem_expbit} <= '0;
                  end else begin
                     elem_idx <= elem_nxt;
                     op       <= 1'b0;
                     {mem_we, mem_wbit, mem_expbit} <= op_decode(elem_nxt, 1'b0);
                  end
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_march_seq_ctrl.sv
// Directed bench for march_seq_ctrl: full runs, stalls, restart/abort/reset cases.
module tb_march_seq_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic        abort;
   logic [15:0] cfg_last_addr;
   logic        mem_ready;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic        mem_wbit;
   logic        mem_expbit;
   logic [2:0]  elem_idx;
   logic        busy;
   logic        done;
   logic        aborted;

   typedef struct packed {
      logic [2:0]  elem;
      logic [15:0] addr;
      logic        we;
      logic        wbit;
      logic        expbit;
   } op_s;

   op_s exp_q[$];
   int  checks = 0;
   int  errors = 0;

   always #5 clk = ~clk;

   march_seq_ctrl #(.ADDR_W(16)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .start         (start),
      .abort         (abort),
      .cfg_last_addr (cfg_last_addr),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_we        (mem_we),
      .mem_wbit      (mem_wbit),
      .mem_expbit    (mem_expbit),
      .elem_idx      (elem_idx),
      .busy          (busy),
      .done          (done),
      .aborted       (aborted)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // code: 0=w0 1=w1 2=r0 3=r1, -1 = no op
   task automatic push(input int e, input int a, input int code);
      op_s o;
      o.elem   = 3'(e);
      o.addr   = 16'(a);
      o.we     = (code < 2);
      o.wbit   = (code == 1);
      o.expbit = (code == 3);
      exp_q.push_back(o);
   endtask

   task automatic build_model(input int last);
      int codes[6][2] = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
      int a;
      exp_q.delete();
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i <= last; i++) begin
            a = (e == 3 || e == 4) ? last - i : i;
            for (int k = 0; k < 2; k++) begin
               if (codes[e][k] >= 0) push(e, a, codes[e][k]);
            end
         end
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, " mem_req"}, mem_req, 0);
      chk({tag, " mem_addr"}, mem_addr, 0);
      chk({tag, " mem_we"}, mem_we, 0);
      chk({tag, " mem_wbit"}, mem_wbit, 0);
      chk({tag, " mem_expbit"}, mem_expbit, 0);
      chk({tag, " elem_idx"}, elem_idx, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " aborted"}, aborted, 0);
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating
   task automatic run_ops(input logic [15:0] last, input int mode, input int restart_at,
                          input int abort_at, input int rst_at, input string tag);
      int   idx;
      int   c;
      logic rdy;
      logic ab;
      cfg_last_addr = last;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, " aborted cleared"}, aborted, 0);
      chk({tag, " busy"}, busy, 1);
      idx = 0;
      c   = 0;
      while (idx < exp_q.size() && c < 400) begin
         rdy = (mode == 0) ? 1'b1 : ((c % 3) == 0);
         mem_ready = rdy;
         chk($sformatf("%s op%0d req", tag, idx), mem_req, 1);
         chk($sformatf("%s op%0d addr", tag, idx), mem_addr, exp_q[idx].addr);
         chk($sformatf("%s op%0d we", tag, idx), mem_we, exp_q[idx].we);
         chk($sformatf("%s op%0d wbit", tag, idx), mem_wbit, exp_q[idx].wbit);
         chk($sformatf("%s op%0d expbit", tag, idx), mem_expbit, exp_q[idx].expbit);
         chk($sformatf("%s op%0d elem", tag, idx), elem_idx, exp_q[idx].elem);
         if (idx == rst_at) begin
            #2 rstn = 1'b0;
            #1;
            chk_idle_zero({tag, " async"});
            return;
         end
         ab = (idx == abort_at);
         abort = ab;
         if (idx == restart_at) begin
            start = 1'b1;
            cfg_last_addr = 16'd7;
         end
         tick();
         abort = 1'b0;
         start = 1'b0;
         c++;
         if (ab) begin
            chk({tag, " abort req"}, mem_req, 0);
            chk({tag, " abort done"}, done, 1);
            chk({tag, " abort aborted"}, aborted, 1);
            chk({tag, " abort busy"}, busy, 0);
            tick();
            chk({tag, " abort done end"}, done, 0);
            return;
         end
         if (rdy) idx++;
      end
      chk({tag, " op count"}, idx, exp_q.size());
      if (mode == 0) chk({tag, " cycles"}, c, exp_q.size());
      chk({tag, " done"}, done, 1);
      chk({tag, " busy fin"}, busy, 0);
      chk({tag, " req fin"}, mem_req, 0);
      chk({tag, " aborted fin"}, aborted, 0);
      tick();
      chk({tag, " done end"}, done, 0);
      chk({tag, " busy end"}, busy, 0);
   endtask

   initial begin
      rstn = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      mem_ready = 1'b0;
      cfg_last_addr = '0;
      #3;
      chk_idle_zero("reset");
      tick();
      tick();
      rstn = 1'b1;
      tick();
      chk_idle_zero("idle");

      build_model(3);
      run_ops(16'd3, 0, -1, -1, -1, "la3");

      build_model(1);
      run_ops(16'd1, 1, -1, -1, -1, "stall");

      exp_q.delete();
      push(0, 0, 0); push(1, 0, 2); push(1, 0, 1); push(2, 0, 3); push(2, 0, 0);
      push(3, 0, 2); push(3, 0, 1); push(4, 0, 3); push(4, 0, 0); push(5, 0, 2);
      run_ops(16'd0, 0, -1, -1, -1, "la0");

      build_model(3);
      run_ops(16'd3, 0, 5, -1, -1, "restart");
      run_ops(16'd3, 0, -1, 7, -1, "abort7");
      run_ops(16'd3, 0, -1, -1, -1, "after_abort");
      run_ops(16'd3, 0, -1, 39, -1, "abort_last");
      run_ops(16'd3, 0, -1, -1, 12, "rst12");

      tick();
      tick();
      rstn = 1'b1;
      mem_ready = 1'b1;
      tick();
      tick();
      tick();
      chk_idle_zero("post_rst");

      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      chk("idle abort aborted", aborted, 0);
      chk("idle abort busy", busy, 0);
      chk("idle abort done", done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
